// File: rtl/booth_product_accumulator.sv
// Saturating multiply-accumulate back end: sums cfg_len signed products
// per frame and hands each frame sum downstream over valid/ready.
module booth_product_accumulator #(
  parameter int PROD_W  = 9,
  parameter int ACC_W   = 16,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [COUNT_W-1:0] cfg_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PROD_W-1:0]  in_product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [COUNT_W:0]   out_count,
  output logic               out_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [COUNT_W:0] FULL_LEN =
    {1'b1, {COUNT_W{1'b0}}};
  localparam logic [COUNT_W:0] ONE =
    {{COUNT_W{1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] MAX_V =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V =
    {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [COUNT_W:0]   cnt_q, cnt_d;
  logic [COUNT_W:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q;
  logic               out_valid_q;

  logic               acc_in;
  logic               acc_out;
  logic [COUNT_W:0]   len_cfg;
  logic [COUNT_W:0]   cnt_inc;
  logic [ACC_W:0]     prod_x;
  logic [ACC_W:0]     sum;
  logic               sat_hi;
  logic               sat_lo;
  logic [ACC_W-1:0]   sat_sum;

  assign acc_in  = in_valid && in_ready_q;
  assign acc_out = out_valid_q && out_ready;
  assign len_cfg = (cfg_len == '0) ? FULL_LEN
                                   : {1'b0, cfg_len};
  assign cnt_inc = cnt_q + ONE;

  assign prod_x = {{(ACC_W+1-PROD_W){in_product[PROD_W-1]}},
                   in_product};
  assign sum    = {acc_q[ACC_W-1], acc_q} + prod_x;

  // Top two bits disagree only when the true sum left the ACC_W range.
  assign sat_hi = !sum[ACC_W] && sum[ACC_W-1];
  assign sat_lo = sum[ACC_W] && !sum[ACC_W-1];

  always_comb begin
    sat_sum = sum[ACC_W-1:0];
    unique case (1'b1)
      sat_hi:  sat_sum = MAX_V;
      sat_lo:  sat_sum = MIN_V;
      default: sat_sum = sum[ACC_W-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      len_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc_in) begin
            acc_d   = prod_x[ACC_W-1:0];
            cnt_d   = ONE;
            len_d   = len_cfg;
            ovf_d   = 1'b0;
            state_d = (len_cfg == ONE) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (acc_in) begin
            acc_d = sat_sum;
            ovf_d = ovf_q | sat_hi | sat_lo;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) state_d = DONE;
          end
        end
        DONE: begin
          if (acc_out) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            len_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d != DONE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = acc_q;
  assign out_count    = cnt_q;
  assign out_overflow = ovf_q;

endmodule
